mem_seq_ctrl: RTL

- Multi-cycle memory stage directly downstream of the MAR/MDR pair. Owns a 256x8 byte-addressed array.
- Serves control-unit requests with the MOV/MOC handshake, for byte, halfword and word sizes selected by typeData.
- Transfers one byte per cycle, big-endian, after a programmable number of wait states.
- Read data feeds MUXE and IR; write data comes from MUXG.

---
 rtl/mem_seq_pkg.sv | 32 +++
 rtl/mem_byte_array.sv | 40 ++++
 rtl/mem_seq_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// Shared encodings, FSM states and the size-to-byte-count helper for the memory sequencer.
package mem_seq_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StXfer,
        StDone
    } state_t;

    // The reserved size maps to 0 bytes; it is rejected before any transfer happens.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        logic [2:0] n;
        n = 3'd0;
        case (sz)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-wide storage: synchronous write, asynchronous read.
// Define MEM_PRELOAD_EN to load the boot image (one byte per entry) at time zero.
module mem_byte_array #(
    parameter int unsigned ADDR_W    = 8,
    parameter string       INIT_FILE = "IR.dat"
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [7:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

    localparam bit unused_init_file = (INIT_FILE != "");

`ifdef MEM_PRELOAD_EN
    localparam int unsigned ImageLen = 4;
    localparam logic [7:0] Image [ImageLen] = '{8'hE3, 8'hA0, 8'h00, 8'h01};

    initial begin
        for (int unsigned i = 0; i < ImageLen && i < Depth; i++) begin
            mem[i] = Image[i];
        end
    end
`endif

endmodule

// File: rtl/mem_seq_ctrl.sv
// Multi-cycle byte-serial memory stage with MOV/MOC handshake, big-endian transfers.
// Optional array preload is compiled in with MEM_PRELOAD_EN.
module mem_seq_ctrl
    import mem_seq_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned ADDR_W      = 8,
    parameter string       INIT_FILE   = "IR.dat"
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        MOV,
    input  logic        RW,
    input  logic [1:0]  typeData,
    input  logic [31:0] addr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        ERR
);

    localparam logic [3:0] WaitLast = 4'(WAIT_STATES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              rw_q, rw_d;
    logic              bad_q, bad_d;
    logic [2:0]        n_q, n_d;
    logic [31:0]       data_q, data_d;
    logic [3:0]        wait_q, wait_d;
    logic [2:0]        byte_q, byte_d;
    logic [31:0]       dout_q, dout_d;
    logic              moc_q, moc_d;
    logic              err_q, err_d;

    logic              we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        wdata;
    logic [7:0]        rdata;
    logic [4:0]        lane_lsb;
    logic [2:0]        req_n;
    logic              req_bad;

    generate
        if (ADDR_W < 32) begin : g_unused_addr
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[31:ADDR_W];
        end
    endgenerate

    // Byte k of an N-byte value sits in lane N-1-k (big-endian, right-justified).
    always_comb begin
        req_n    = size_bytes(typeData);
        req_bad  = (typeData == SZ_RSVD) ||
                   (typeData == SZ_HALF && addr[0]) ||
                   (typeData == SZ_WORD && addr[1:0] != 2'b00);
        lane_lsb = {2'(n_q - 3'd1 - byte_q), 3'b000};
        mem_addr = base_q + ADDR_W'(byte_q);
        wdata    = data_q[lane_lsb +: 8];
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        rw_d    = rw_q;
        bad_d   = bad_q;
        n_d     = n_q;
        data_d  = data_q;
        wait_d  = wait_q;
        byte_d  = byte_q;
        dout_d  = dout_q;
        moc_d   = moc_q;
        err_d   = err_q;
        we      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (MOV) begin
                    base_d = addr[ADDR_W-1:0];
                    rw_d   = RW;
                    n_d    = req_n;
                    data_d = DataIn;
                    bad_d  = req_bad;
                    wait_d = 4'd0;
                    byte_d = 3'd0;
                    if (req_bad) begin
                        state_d = StDone;
                    end else if (WAIT_STATES == 0) begin
                        state_d = StXfer;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (wait_q == WaitLast) begin
                    wait_d  = 4'd0;
                    state_d = StXfer;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            StXfer: begin
                if (rw_q == RW_WRITE) begin
                    we = 1'b1;
                end else begin
                    // First read byte clears the stale upper lanes.
                    if (byte_q == 3'd0) begin
                        dout_d = '0;
                    end
                    dout_d[lane_lsb +: 8] = rdata;
                end
                if (byte_q == n_q - 3'd1) begin
                    byte_d  = 3'd0;
                    state_d = StDone;
                end else begin
                    byte_d = byte_q + 3'd1;
                end
            end
            StDone: begin
                // MOC rises one cycle after entering DONE, then waits for MOV to drop.
                if (!moc_q) begin
                    moc_d = 1'b1;
                    err_d = bad_q;
                end else if (!MOV) begin
                    moc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= StIdle;
            base_q  <= '0;
            rw_q    <= RW_READ;
            bad_q   <= 1'b0;
            n_q     <= 3'd0;
            data_q  <= '0;
            wait_q  <= 4'd0;
            byte_q  <= 3'd0;
            dout_q  <= '0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            rw_q    <= rw_d;
            bad_q   <= bad_d;
            n_q     <= n_d;
            data_q  <= data_d;
            wait_q  <= wait_d;
            byte_q  <= byte_d;
            dout_q  <= dout_d;
            moc_q   <= moc_d;
            err_q   <= err_d;
        end
    end

    mem_byte_array #(
        .ADDR_W   (ADDR_W),
        .INIT_FILE(INIT_FILE)
    ) u_array (
        .clk  (CLK),
        .we   (we),
        .waddr(mem_addr),
        .wdata(wdata),
        .raddr(mem_addr),
        .rdata(rdata)
    );

    assign DataOut = dout_q;
    assign MOC     = moc_q;
    assign ERR     = err_q;

endmodule
